// File: rtl/shru_store_unit_if.sv
// Data-cache store port of the shadow-register store unit.
// The unit drives requests through the master modport; the cache answers through the slave modport.
interface shru_store_unit_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned VLEN = 64
);

  logic              dc_req;
  logic              dc_gnt;
  logic [VLEN-1:0]   dc_addr;
  logic [XLEN-1:0]   dc_wdata;
  logic [XLEN/8-1:0] dc_be;
  logic              dc_we;

  modport master (
    output dc_req,
    output dc_addr,
    output dc_wdata,
    output dc_be,
    output dc_we,
    input  dc_gnt
  );

  modport slave (
    input  dc_req,
    input  dc_addr,
    input  dc_wdata,
    input  dc_be,
    input  dc_we,
    output dc_gnt
  );

endinterface

// File: rtl/shru_store_unit.sv
// Shadow-register store unit: latches a save frame (data, mask, level, base address)
// and streams the masked words to the data cache, lowest index first.
// Optional feature macro: SHRU_FLUSH_ABORT_EN -- when defined, flush_i during the
// store phase drops the remaining words and pulses aborted_o instead of store_valid_o.
module shru_store_unit #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned VLEN     = 64,
  parameter int unsigned NR_WORDS = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     save_valid_i,
  output logic                     save_ready_o,
  input  logic [VLEN-1:0]          base_addr_i,
  input  logic [NR_WORDS*XLEN-1:0] save_data_i,
  input  logic [NR_WORDS-1:0]      save_mask_i,
  input  logic [4:0]               save_level_i,
  output logic [4:0]               save_level_o,
  output logic                     store_valid_o,
  output logic                     aborted_o,
  input  logic [11:0]              page_offset_i,
  output logic                     page_offset_match_o,
  shru_store_unit_if.master        dc
);

  localparam int unsigned STRIDE   = XLEN / 8;
  localparam int unsigned IDX_W    = (NR_WORDS > 1) ? $clog2(NR_WORDS) : 1;
  localparam logic [11:0] OFF_MASK = ~12'(STRIDE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STORE,
    ST_DONE
  } state_e;

  state_e                     r_state;
  logic [NR_WORDS-1:0]        r_pend;
  logic [NR_WORDS*XLEN-1:0]   r_data;
  logic [VLEN-1:0]            r_base;
  logic [4:0]                 r_level;
  logic [IDX_W-1:0]           r_idx;
  logic [VLEN-1:0]            r_addr;
  logic [XLEN-1:0]            r_wdata;

  logic                       w_idle;
  logic                       w_ready;
  logic [VLEN-1:0]            w_base_al;
  logic [NR_WORDS-1:0]        w_rest;
  logic [NR_WORDS-1:0]        w_sel_vec;
  logic [VLEN-1:0]            w_src_base;
  logic [NR_WORDS*XLEN-1:0]   w_src_data;
  logic [IDX_W-1:0]           w_nidx;
  logic [VLEN-1:0]            w_naddr;
  logic [XLEN-1:0]            w_nwdata;
  logic [11:0]                w_woff;
  logic                       w_match;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_ready      = w_idle & ~flush_i;
  assign save_ready_o = w_ready;

  // Save frames are word aligned; the low address bits are dropped at accept.
  assign w_base_al = base_addr_i & ~VLEN'(STRIDE - 1);

  // Pending words left once the currently presented word is granted.
  assign w_rest = r_pend & ~(NR_WORDS'(1) << r_idx);

  // In IDLE the next word comes from the incoming request, otherwise from the latched frame.
  assign w_sel_vec  = w_idle ? save_mask_i : w_rest;
  assign w_src_base = w_idle ? w_base_al   : r_base;
  assign w_src_data = w_idle ? save_data_i : r_data;

  // Lowest set bit of the candidate vector selects the next word to present.
  always_comb begin
    w_nidx = '0;
    for (int i = int'(NR_WORDS) - 1; i >= 0; i--) begin
      if (w_sel_vec[i]) w_nidx = IDX_W'(i);
    end
  end

  assign w_naddr  = w_src_base + VLEN'(w_nidx) * VLEN'(STRIDE);
  assign w_nwdata = w_src_data[int'(w_nidx)*XLEN +: XLEN];

  // A load hits a pending store when their word offsets within the page agree.
  always_comb begin
    w_match = 1'b0;
    w_woff  = '0;
    for (int i = 0; i < int'(NR_WORDS); i++) begin
      w_woff = r_base[11:0] + 12'(i) * 12'(STRIDE);
      if ((r_state == ST_STORE) && r_pend[i] &&
          (((w_woff ^ page_offset_i) & OFF_MASK) == 12'd0)) begin
        w_match = 1'b1;
      end
    end
  end

  assign page_offset_match_o = w_match;

  assign dc.dc_req   = (r_state == ST_STORE);
  assign dc.dc_we    = (r_state == ST_STORE);
  assign dc.dc_be    = '1;
  assign dc.dc_addr  = r_addr;
  assign dc.dc_wdata = r_wdata;

  assign store_valid_o = (r_state == ST_DONE);
  assign save_level_o  = r_level;

`ifdef SHRU_FLUSH_ABORT_EN
  logic r_aborted;
  assign aborted_o = r_aborted;
`else
  assign aborted_o = 1'b0;
`endif

  // Save FSM: accept a frame, stream its words on grants, then report completion.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_pend    <= '0;
      r_data    <= '0;
      r_base    <= '0;
      r_level   <= '0;
      r_idx     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
`ifdef SHRU_FLUSH_ABORT_EN
      r_aborted <= 1'b0;
`endif
    end else begin
`ifdef SHRU_FLUSH_ABORT_EN
      r_aborted <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (save_valid_i && w_ready) begin
            r_base  <= w_base_al;
            r_data  <= save_data_i;
            r_level <= save_level_i;
            r_pend  <= save_mask_i;
            if (|save_mask_i) begin
              r_state <= ST_STORE;
              r_idx   <= w_nidx;
              r_addr  <= w_naddr;
              r_wdata <= w_nwdata;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_STORE: begin
          if (dc.dc_gnt) begin
            r_pend <= w_rest;
            if (~|w_rest) begin
              r_state <= ST_DONE;
            end else begin
              r_idx   <= w_nidx;
              r_addr  <= w_naddr;
              r_wdata <= w_nwdata;
            end
          end
`ifdef SHRU_FLUSH_ABORT_EN
          // A grant in the flush cycle still lands; everything after it is dropped.
          if (flush_i) begin
            r_pend    <= '0;
            r_state   <= ST_IDLE;
            r_aborted <= 1'b1;
          end
`endif
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
